// File: rtl/bus_arbiter_pkg.sv
// Shared state, port-select and memory-command definitions for the fetch/data bus arbiter.
// Pure declarations: no latency and no flow control of their own.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int TMR_W           = 8;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  // Fetches are always word-aligned reads.
  function automatic mem_cmd_t fetch_cmd(input logic [29:0] word_addr);
    mem_cmd_t c;
    c.we    = 4'b0000;
    c.addr  = {word_addr, 2'b00};
    c.wdata = 32'h0000_0000;
    return c;
  endfunction

  function automatic mem_cmd_t data_cmd(input logic [3:0] we, input logic [31:0] addr,
                                        input logic [31:0] wdata);
    mem_cmd_t c;
    c.we    = we;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/bus_arbiter_timer.sv
// bus_timer: clearable cycle counter whose tc marks the final cycle before LIMIT is reached.
// tc is decoded straight from the count register; counting stalls while en is low.
module bus_timer
  import bus_arbiter_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TMR_W-1:0] TC_VAL = TMR_W'(LIMIT - 1);

  logic [TMR_W-1:0] count;

  // Saturating at TC_VAL keeps tc asserted if the owner lingers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != TC_VAL)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin share of one memory port between fetch and data requesters; 3 cycles min per transaction.
// Requesters hold req until their one-cycle ack; memory stalls via late mem_ack, bounded by TIMEOUT.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [29:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  state_t      state;
  logic        last_served;
  logic        grant;
  logic        pick;
  mem_cmd_t    cmd_sel;
  logic        tmr_tc;
  logic        done;
  logic        rsp_err;
  logic [31:0] rsp_dat;

  always_comb begin
    pick = PORT_I;
    if (i_req && d_req) begin
      pick = (last_served == PORT_D) ? PORT_I : PORT_D;
    end else if (d_req) begin
      pick = PORT_D;
    end
    cmd_sel = (pick == PORT_D) ? data_cmd(d_we, d_addr, d_wdata) : fetch_cmd(i_addr);
  end

  // A mem_ack on the timeout cycle still completes the transaction cleanly.
  assign done    = mem_ack || tmr_tc;
  assign rsp_err = !mem_ack;
  assign rsp_dat = mem_ack ? mem_rdata : 32'h0000_0000;

  bus_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != BUSY),
    .en    ((state == BUSY) && !mem_ack),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= PORT_D;
      grant       <= PORT_I;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 4'b0000;
      mem_addr    <= 32'h0000_0000;
      mem_wdata   <= 32'h0000_0000;
      i_ack       <= 1'b0;
      i_err       <= 1'b0;
      i_rdata     <= 32'h0000_0000;
      d_ack       <= 1'b0;
      d_err       <= 1'b0;
      d_rdata     <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state     <= BUSY;
            busy      <= 1'b1;
            grant     <= pick;
            mem_req   <= 1'b1;
            mem_we    <= cmd_sel.we;
            mem_addr  <= cmd_sel.addr;
            mem_wdata <= cmd_sel.wdata;
          end
        end
        BUSY: begin
          if (done) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 4'b0000;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            if (grant == PORT_D) begin
              d_ack   <= 1'b1;
              d_err   <= rsp_err;
              d_rdata <= rsp_dat;
            end else begin
              i_ack   <= 1'b1;
              i_err   <= rsp_err;
              i_rdata <= rsp_dat;
            end
          end
        end
        RESP: begin
          state       <= IDLE;
          busy        <= 1'b0;
          last_served <= grant;
          i_ack       <= 1'b0;
          i_err       <= 1'b0;
          d_ack       <= 1'b0;
          d_err       <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table plus scoreboard on the default-timeout instance,
// hand sequences for timeout, spurious ack and mid-transaction reset.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        i_req = 1'b0;
  logic [29:0] i_addr = '0;
  logic        i_ack, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy;

  logic        t_i_req = 1'b0;
  logic [29:0] t_i_addr = '0;
  logic        t_i_ack, t_i_err;
  logic [31:0] t_i_rdata;
  logic        t_d_req = 1'b0;
  logic [3:0]  t_d_we = '0;
  logic [31:0] t_d_addr = 32'h44;
  logic [31:0] t_d_wdata = '0;
  logic        t_d_ack, t_d_err;
  logic [31:0] t_d_rdata;
  logic        t_mem_req;
  logic [3:0]  t_mem_we;
  logic [31:0] t_mem_addr, t_mem_wdata;
  logic [31:0] t_mem_rdata = 32'hCAFE_F00D;
  logic        t_mem_ack = 1'b0;
  logic        t_busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  bus_arbiter #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .i_req(t_i_req), .i_addr(t_i_addr), .i_ack(t_i_ack), .i_err(t_i_err), .i_rdata(t_i_rdata),
    .d_req(t_d_req), .d_we(t_d_we), .d_addr(t_d_addr), .d_wdata(t_d_wdata),
    .d_ack(t_d_ack), .d_err(t_d_err), .d_rdata(t_d_rdata),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_rdata(t_mem_rdata), .mem_ack(t_mem_ack), .busy(t_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory models: ack after a programmable number of BUSY cycles (0 = never).
  int          ack_delay = 1;
  logic [31:0] rd_val = '0;
  logic        spur_ack = 1'b0;
  int          bcnt = 0;
  int          t_delay = 0;
  int          tcnt = 0;

  always @(posedge clk) begin
    #1;
    if (mem_req) bcnt = bcnt + 1;
    else bcnt = 0;
    mem_ack   = spur_ack || (mem_req && ack_delay != 0 && bcnt == ack_delay);
    mem_rdata = mem_ack ? rd_val : 32'h0BAD_0BAD;
  end

  always @(posedge clk) begin
    #1;
    if (t_mem_req) tcnt = tcnt + 1;
    else tcnt = 0;
    t_mem_ack = t_mem_req && t_delay != 0 && tcnt == t_delay;
  end

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } cmd_t;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    logic        use_i;
    logic [29:0] iaddr;
    logic [31:0] daddr;
    logic [3:0]  we;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  // Scoreboard monitor on the default-timeout instance.
  int          cyc = 0;
  int          last_ack_cyc = -100;
  int          blen = 0;
  logic        prev_req = 1'b0;
  cmd_t        cur;
  rsp_t        er;
  logic [31:0] m_i_rdata = '0;
  logic [31:0] m_d_rdata = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req     = 1'b0;
      last_ack_cyc = -100;
      m_i_rdata    = '0;
      m_d_rdata    = '0;
    end else begin
      cyc = cyc + 1;
      check("busy_vs_activity", busy, mem_req | i_ack | d_ack);
      if (mem_req && !prev_req) begin
        blen = 1;
        if (cmd_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_mem_req: addr %h with no pending command", mem_addr);
        end else begin
          cur = cmd_q.pop_front();
          check("mem_addr", mem_addr, cur.addr);
          check("mem_we", mem_we, cur.we);
          check("mem_wdata", mem_wdata, cur.wdata);
        end
      end else if (mem_req) begin
        blen = blen + 1;
        check("mem_addr_stable", mem_addr, cur.addr);
        check("mem_we_stable", mem_we, cur.we);
        check("mem_wdata_stable", mem_wdata, cur.wdata);
      end else if (prev_req) begin
        check("busy_len", blen, cur.len);
      end
      prev_req = mem_req;

      if (i_ack || d_ack) begin
        check("ack_onehot", i_ack & d_ack, 1'b0);
        check("ack_gap_ok", (cyc - last_ack_cyc) >= 3, 1'b1);
        last_ack_cyc = cyc;
        if (rsp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_ack: i_ack=%0b d_ack=%0b, expected none", i_ack, d_ack);
        end else begin
          er = rsp_q.pop_front();
          check("ack_port", d_ack, er.port);
          if (d_ack) begin
            check("d_err", d_err, er.err);
            check("d_rdata", d_rdata, er.rdata);
            check("i_err_quiet", i_err, 1'b0);
            check("i_rdata_hold", i_rdata, m_i_rdata);
            m_d_rdata = er.rdata;
          end else begin
            check("i_err", i_err, er.err);
            check("i_rdata", i_rdata, er.rdata);
            check("d_err_quiet", d_err, 1'b0);
            check("d_rdata_hold", d_rdata, m_d_rdata);
            m_i_rdata = er.rdata;
          end
        end
      end else begin
        check("err_without_ack", i_err | d_err, 1'b0);
      end
    end
  end

  task automatic wait_ack(output logic got, output int lat);
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #2;
      if (i_ack || d_ack) begin
        got = 1'b1;
        lat = k + 1;
        break;
      end
    end
    check("ack_seen", got, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    cmd_t c;
    rsp_t r;
    logic got;
    int   lat;
    c.we = v.exp_we; c.addr = v.exp_maddr; c.wdata = v.exp_wdata; c.len = v.delay;
    cmd_q.push_back(c);
    r.port = v.use_i ? 1'b0 : 1'b1; r.err = 1'b0; r.rdata = v.rdata;
    rsp_q.push_back(r);
    ack_delay = v.delay;
    rd_val    = v.rdata;
    if (v.use_i) begin
      i_addr = v.iaddr; d_we = 4'hF; d_addr = 32'hFFFF_FFFF; d_wdata = 32'hFFFF_FFFF;
      i_req = 1'b1;
    end else begin
      d_we = v.we; d_addr = v.daddr; d_wdata = v.wdata; i_addr = 30'h3FFF_FFFF;
      d_req = 1'b1;
    end
    wait_ack(got, lat);
    check({tag, "_latency"}, lat, v.delay + 1);
    i_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk); #2;
  endtask

  // Both requesters held: grants must alternate starting with fetch.
  task automatic run_tie(input int n);
    cmd_t c;
    rsp_t r;
    logic got;
    int   lat;
    for (int j = 0; j < n; j++) begin
      if (j % 2 == 0) begin
        c.we = 4'b0000; c.addr = 32'h154; c.wdata = 32'h0; r.port = 1'b0;
      end else begin
        c.we = 4'b1000; c.addr = 32'h300; c.wdata = 32'h8800_0000; r.port = 1'b1;
      end
      c.len = 1; r.err = 1'b0; r.rdata = 32'h7777_1111;
      cmd_q.push_back(c);
      rsp_q.push_back(r);
    end
    ack_delay = 1; rd_val = 32'h7777_1111;
    i_addr = 30'h55; d_addr = 32'h300; d_we = 4'b1000; d_wdata = 32'h8800_0000;
    i_req = 1'b1; d_req = 1'b1;
    for (int j = 0; j < n; j++) begin
      wait_ack(got, lat);
      if (!got) break;
      check("tie_latency", lat, (j == 0) ? 2 : 3);
    end
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic t_run(input int delay, input logic exp_err, input logic [31:0] exp_rd, input int exp_len);
    logic got;
    int   len;
    got = 1'b0; len = 0;
    t_delay = delay;
    t_d_req = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      if (t_mem_req) len++;
      if (t_d_ack) begin
        got = 1'b1;
        break;
      end
    end
    check("to_ack_seen", got, 1'b1);
    check("to_busy_len", len, exp_len);
    check("to_d_err", t_d_err, exp_err);
    check("to_d_rdata", t_d_rdata, exp_rd);
    check("to_i_quiet", {t_i_ack, t_i_err}, 2'b00);
    t_d_req = 1'b0;
    @(posedge clk); #2;
    check("to_d_ack_width", t_d_ack, 1'b0);
  endtask

  vec_t vecs[6];
  int   acks_seen;

  initial begin
    vecs[0] = '{1'b1, 30'h10, 32'h0, 4'h0, 32'h0, 1, 32'hDEAD_BEEF, 32'h40, 4'h0, 32'h0};
    vecs[1] = '{1'b0, 30'h0, 32'h104, 4'b0011, 32'h1234_5678, 5, 32'hA5A5_0001, 32'h104, 4'b0011, 32'h1234_5678};
    vecs[2] = '{1'b0, 30'h0, 32'h2000_0008, 4'h0, 32'h0, 2, 32'h0BAD_CAFE, 32'h2000_0008, 4'h0, 32'h0};
    vecs[3] = '{1'b1, 30'h3FFF_FFFF, 32'h0, 4'h0, 32'h0, 3, 32'h1357_9BDF, 32'hFFFF_FFFC, 4'h0, 32'h0};
    vecs[4] = '{1'b0, 30'h0, 32'hFFFF_FFF0, 4'hF, 32'hFFFF_0000, 1, 32'h0F0F_0F0F, 32'hFFFF_FFF0, 4'hF, 32'hFFFF_0000};
    vecs[5] = '{1'b1, 30'h123, 32'h0, 4'h0, 32'h0, 1, 32'h2468_ACE0, 32'h48C, 4'h0, 32'h0};

    repeat (2) @(posedge clk);
    #2;
    check("rst_flags", {i_ack, d_ack, i_err, d_err, busy, mem_req}, 6'b0);
    check("rst_mem_we", mem_we, 4'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_to_busy", t_busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    run_tie(3);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    spur_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      check("spur_idle", {busy, mem_req, i_ack, d_ack}, 4'b0);
    end
    spur_ack = 1'b0;
    @(posedge clk); #2;

    cur.len = 0;
    cmd_q.push_back('{4'h0, 32'h80, 32'h0, 0});
    ack_delay = 0;
    d_we = 4'h0; d_addr = 32'h80; d_wdata = 32'h0;
    d_req = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_mem_req", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {i_ack, d_ack, i_err, d_err, busy, mem_req}, 6'b0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_i_rdata", i_rdata, 32'h0);
    check("midrst_d_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    ack_delay = 1;
    acks_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      if (i_ack || d_ack) acks_seen++;
    end
    check("no_ack_after_reset", acks_seen, 0);

    run_tie(2);
    run_vec(vecs[1], "post_rst");

    t_run(0, 1'b1, 32'h0, 4);
    t_run(4, 1'b0, 32'hCAFE_F00D, 4);
    t_run(2, 1'b0, 32'hCAFE_F00D, 2);
    t_run(0, 1'b1, 32'h0, 4);

    check("cmd_q_drained", cmd_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
